cache_p_control: RTL and testbench
==================================

# cache_p_control

Control FSM for the pipelined 4-way set-associative cache datapath (cache_p_datapath). It decodes the hit and dirty status of the request held in the datapath's IF/ID stage and drives the datapath's `load`, `load_lru`, `address_sel`, `access_sel` and `stall` selects. On a miss it sequences a victim writeback and a line fill over the cache-adapter/physical-memory port, then replays the held request. It sits between the datapath and the cache adapter and returns `mem_resp` to the CPU pipeline.

## Interface
Parameters:
- CNT_W, 32, width of each performance counter (used only with CACHE_PERF_EN)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- read_i  in  1  held IF/ID request is a read (datapath `read_o`)
- write_i  in  1  held IF/ID request is a write (datapath `write_o`)
- cache_hit  in  1  a valid way's tag matches the held address
- dirty  in  1  the selected way (hit way or LRU victim) is dirty
- pmem_resp  in  1  cache adapter has completed the current pmem transfer
- load  out  1  write the selected way: data, tag, valid, dirty
- load_lru  out  1  update the LRU array for the held index
- address_sel  out  1  1 = pmem address is the victim {tag, index, 0}; 0 = held address
- access_sel  out  1  1 = way input is pmem_rdata with a full mask; 0 = CPU data with byte enables
- stall  out  1  freezes the IF/ID register and LRU update
- mem_resp  out  1  one-cycle completion strobe to the CPU
- pmem_read  out  1  line read request to the cache adapter
- pmem_write  out  1  line write request to the cache adapter
- hit_count, miss_count, wb_count  out  CNT_W  performance counters (present only with CACHE_PERF_EN)

## Operation
- Request present = read_i | write_i. If both are asserted, the request is handled as a write.
- States: CHECK, WB, FILL, REPLAY. Reset state: CHECK.
- Every output not listed for a state is 0.
- CHECK, no request: all outputs 0. Stay in CHECK.
- CHECK, request and cache_hit:
  - mem_resp=1, load_lru=1, load=write_i, access_sel=0, stall=0.
  - Stay in CHECK, so a back-to-back request is accepted.
- CHECK, request and !cache_hit:
  - stall=1.
  - Next state is WB if dirty, otherwise FILL.
- WB: address_sel=1, pmem_write=1, stall=1. On pmem_resp, go to FILL.
- FILL:
  - address_sel=0, access_sel=1, pmem_read=1, stall=1.
  - load=pmem_resp, so the LRU way is written with the fetched line and its valid bit set.
  - On pmem_resp, go to REPLAY.
- REPLAY:
  - stall=1; no other outputs.
  - Waits one cycle so the synchronous way read reflects the filled line.
  - Always goes to CHECK, where the held request then hits and completes normally (a write merges its bytes and sets dirty).
- pmem_resp is ignored in CHECK and REPLAY.
- pmem_read and pmem_write are never asserted together.
- Outputs are Moore, except that in CHECK the outputs depend on cache_hit, dirty and the request inputs, and FILL's load depends on pmem_resp.

## Timing
- Reset (rst=0): takes effect immediately, asynchronously.
  - State goes to CHECK; all outputs 0; counters 0.
  - An in-flight pmem_read or pmem_write drops in the same cycle.
- Hit latency: mem_resp in the same cycle the request is presented in the IF/ID stage (0 added cycles).
- Clean miss, with pmem_resp arriving k cycles into FILL (k≥1):
  - Cycle 0: CHECK, miss.
  - Cycles 1..k: FILL.
  - Cycle k+1: REPLAY.
  - Cycle k+2: CHECK, mem_resp.
- Dirty miss: adds j WB cycles before FILL, where pmem_resp arrives j cycles into WB.
- pmem_resp held high for several cycles: each cycle advances at most one state. Designs are verified with single-cycle pmem_resp.

## Configuration
- Macro: CACHE_PERF_EN.
- Defined:
  - hit_count increments on a CHECK hit cycle that is not the post-REPLAY completion. A one-bit replay flag is set on entry to REPLAY and cleared in CHECK.
  - miss_count increments on each CHECK miss.
  - wb_count increments on each WB→FILL transition.
  - All counters saturate at 2^CNT_W−1.
- Undefined: the counter ports and logic are absent; FSM behaviour is identical.

## Test plan
- Read hit, dirty don't-care: read_i=1, cache_hit=1 → mem_resp=1, load_lru=1, load=0, stall=0 in the same cycle.
- Clean read miss: cache_hit=0, dirty=0, pmem_resp on the 3rd FILL cycle → pmem_read asserted for 3 cycles, load=1 only on the 3rd, one REPLAY cycle, mem_resp 5 cycles after the miss cycle.
- Dirty write miss: dirty=1, pmem_resp after 2 WB cycles then 2 FILL cycles → address_sel=1 with pmem_write for 2 cycles, then access_sel=1 with pmem_read for 2 cycles, then REPLAY; the final CHECK has load=1, access_sel=0, mem_resp=1.
- Reset mid-WB: rst=0 while pmem_write=1 → pmem_write=0 and stall=0 immediately; after release, the FSM is in CHECK.
- Stray pmem_resp=1 in CHECK with no request → no state change, all outputs 0.
- CACHE_PERF_EN: 3 hits, 1 clean miss, 1 dirty miss → hit_count=3, miss_count=2, wb_count=1. Repeat with CNT_W=2 over 5 hits → hit_count saturates at 3.

Source files
------------

// File: rtl/cache_p_control.sv
// Control FSM for the pipelined 4-way set-associative cache: hit decode, victim writeback, line fill and replay.
// Optional performance counters are enabled with `define CACHE_PERF_EN.
module cache_p_control #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             read_i,
    input  logic             write_i,
    input  logic             cache_hit,
    input  logic             dirty,
    input  logic             pmem_resp,
    output logic             load,
    output logic             load_lru,
    output logic             address_sel,
    output logic             access_sel,
    output logic             stall,
    output logic             mem_resp,
    output logic             pmem_read,
    output logic             pmem_write
`ifdef CACHE_PERF_EN
    ,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
    output logic [CNT_W-1:0] wb_count
`endif
);

    typedef enum logic [1:0] {
        S_CHECK  = 2'd0,
        S_WB     = 2'd1,
        S_FILL   = 2'd2,
        S_REPLAY = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   req;

    assign req = read_i | write_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_CHECK;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and select decode; reset forces every output low at once.
    always_comb begin
        state_nxt   = state;
        load        = 1'b0;
        load_lru    = 1'b0;
        address_sel = 1'b0;
        access_sel  = 1'b0;
        stall       = 1'b0;
        mem_resp    = 1'b0;
        pmem_read   = 1'b0;
        pmem_write  = 1'b0;
        case (state)
            S_CHECK: begin
                if (req) begin
                    if (cache_hit) begin
                        mem_resp = 1'b1;
                        load_lru = 1'b1;
                        load     = write_i;
                    end else begin
                        stall     = 1'b1;
                        state_nxt = dirty ? S_WB : S_FILL;
                    end
                end
            end
            S_WB: begin
                address_sel = 1'b1;
                pmem_write  = 1'b1;
                stall       = 1'b1;
                if (pmem_resp) begin
                    state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                access_sel = 1'b1;
                pmem_read  = 1'b1;
                stall      = 1'b1;
                load       = pmem_resp;
                if (pmem_resp) begin
                    state_nxt = S_REPLAY;
                end
            end
            S_REPLAY: begin
                stall     = 1'b1;
                state_nxt = S_CHECK;
            end
            default: begin
                state_nxt = S_CHECK;
            end
        endcase
        if (!rst) begin
            load        = 1'b0;
            load_lru    = 1'b0;
            address_sel = 1'b0;
            access_sel  = 1'b0;
            stall       = 1'b0;
            mem_resp    = 1'b0;
            pmem_read   = 1'b0;
            pmem_write  = 1'b0;
        end
    end

`ifdef CACHE_PERF_EN
    logic replay_flag;
    logic hit_inc;
    logic miss_inc;
    logic wb_inc;

    assign hit_inc  = (state == S_CHECK) && req && cache_hit && !replay_flag;
    assign miss_inc = (state == S_CHECK) && req && !cache_hit;
    assign wb_inc   = (state == S_WB) && pmem_resp;

    // The completion after a replay is the tail of a miss, not a fresh hit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            replay_flag <= 1'b0;
        end else if (state == S_FILL && pmem_resp) begin
            replay_flag <= 1'b1;
        end else if (state == S_CHECK) begin
            replay_flag <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            if (hit_inc && (hit_count != '1)) begin
                hit_count <= hit_count + CNT_W'(1);
            end
            if (miss_inc && (miss_count != '1)) begin
                miss_count <= miss_count + CNT_W'(1);
            end
            if (wb_inc && (wb_count != '1)) begin
                wb_count <= wb_count + CNT_W'(1);
            end
        end
    end
`else
    if (CNT_W == 0) begin : g_cnt_w_zero
    end
`endif

endmodule

// File: tb/tb_cache_p_control.sv
// Self-checking bench for cache_p_control: a transaction-level model expands each request into the
// expected per-cycle select trace; counters are checked when CACHE_PERF_EN is defined.
module tb_cache_p_control;

    localparam int unsigned CNT_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic read_i = 1'b0;
    logic write_i = 1'b0;
    logic cache_hit = 1'b0;
    logic dirty = 1'b0;
    logic pmem_resp = 1'b0;
    logic load, load_lru, address_sel, access_sel, stall, mem_resp, pmem_read, pmem_write;
    logic [7:0] outs;

    always #5 clk = ~clk;

    assign outs = {load, load_lru, address_sel, access_sel, stall, mem_resp, pmem_read, pmem_write};

`ifdef CACHE_PERF_EN
    logic [CNT_W-1:0] hit_count, miss_count, wb_count;
    logic s_load, s_load_lru, s_address_sel, s_access_sel, s_stall, s_mem_resp, s_pmem_read, s_pmem_write;
    logic [1:0] s_hit_count, s_miss_count, s_wb_count;
    logic [7:0] s_outs;
    assign s_outs = {s_load, s_load_lru, s_address_sel, s_access_sel, s_stall, s_mem_resp, s_pmem_read, s_pmem_write};
`endif

    cache_p_control #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .read_i(read_i), .write_i(write_i), .cache_hit(cache_hit),
        .dirty(dirty), .pmem_resp(pmem_resp), .load(load), .load_lru(load_lru),
        .address_sel(address_sel), .access_sel(access_sel), .stall(stall), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write)
`ifdef CACHE_PERF_EN
        , .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
    );

`ifdef CACHE_PERF_EN
    cache_p_control #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .read_i(read_i), .write_i(write_i), .cache_hit(cache_hit),
        .dirty(dirty), .pmem_resp(pmem_resp), .load(s_load), .load_lru(s_load_lru),
        .address_sel(s_address_sel), .access_sel(s_access_sel), .stall(s_stall), .mem_resp(s_mem_resp),
        .pmem_read(s_pmem_read), .pmem_write(s_pmem_write),
        .hit_count(s_hit_count), .miss_count(s_miss_count), .wb_count(s_wb_count)
    );
`endif

    typedef struct {
        logic       rd;
        logic       wr;
        logic       hit;
        logic       dty;
        logic       resp;
        logic [7:0] exp;
    } step_t;

    step_t      q[$];
    logic [7:0] obs[$];
    logic [7:0] obs2[$];
    int n_cmp = 0;
    int n_bad = 0;
    int m_hits, m_miss, m_wb;

    // Expected output vector: {load, load_lru, address_sel, access_sel, stall, mem_resp, pmem_read, pmem_write}
    function automatic logic [7:0] ov(bit ld, bit lru, bit as, bit acc, bit st, bit mr, bit pr, bit pw);
        return {ld, lru, as, acc, st, mr, pr, pw};
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(1, 0));
    endfunction

    function automatic int sat(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic void add_idle(bit force_resp);
        step_t s;
        s = '{1'b0, 1'b0, rbit(), rbit(), force_resp ? 1'b1 : rbit(), 8'h00};
        q.push_back(s);
    endfunction

    // Transaction model: a request either completes at once or runs miss -> [WB x j] -> FILL x k -> REPLAY -> completion.
    function automatic void add_txn(bit rd, bit wr, bit hit, bit dty, int j, int k);
        step_t s;
        logic [7:0] done;
        done = ov(wr, 1, 0, 0, 0, 1, 0, 0);
        if (hit) begin
            s = '{rd, wr, 1'b1, rbit(), rbit(), done};
            q.push_back(s);
            m_hits++;
            return;
        end
        m_miss++;
        s = '{rd, wr, 1'b0, dty, rbit(), ov(0, 0, 0, 0, 1, 0, 0, 0)};
        q.push_back(s);
        if (dty) begin
            m_wb++;
            for (int c = 1; c <= j; c++) begin
                s = '{rd, wr, 1'b0, rbit(), (c == j), ov(0, 0, 1, 0, 1, 0, 0, 1)};
                q.push_back(s);
            end
        end
        for (int c = 1; c <= k; c++) begin
            s = '{rd, wr, 1'b0, rbit(), (c == k), ov(c == k, 0, 0, 1, 1, 0, 1, 0)};
            q.push_back(s);
        end
        s = '{rd, wr, 1'b1, rbit(), rbit(), ov(0, 0, 0, 0, 1, 0, 0, 0)};
        q.push_back(s);
        s = '{rd, wr, 1'b1, rbit(), rbit(), done};
        q.push_back(s);
    endfunction

    task automatic do_reset();
        read_i = 0; write_i = 0; cache_hit = 0; dirty = 0; pmem_resp = 0;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        m_hits = 0; m_miss = 0; m_wb = 0;
        q.delete();
    endtask

    // Drives the queued steps one per cycle and records outputs mid-cycle.
    task automatic apply_queue();
        obs.delete();
        obs2.delete();
        foreach (q[i]) begin
            read_i = q[i].rd; write_i = q[i].wr; cache_hit = q[i].hit;
            dirty = q[i].dty; pmem_resp = q[i].resp;
            @(negedge clk);
            obs.push_back(outs);
`ifdef CACHE_PERF_EN
            obs2.push_back(s_outs);
`endif
            @(posedge clk);
            #1;
        end
        read_i = 0; write_i = 0; cache_hit = 0; dirty = 0; pmem_resp = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        read_i = 1; cache_hit = 1; write_i = 1;
        #1;
        n_cmp++;
        if (outs !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want %b", outs, 8'h00);
        end
`ifdef CACHE_PERF_EN
        n_cmp++;
        if (hit_count !== '0 || miss_count !== '0 || wb_count !== '0) begin
            n_bad++;
            $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0", hit_count, miss_count, wb_count);
        end
`endif
        do_reset();
    endtask

    task automatic test_read_hit();
        do_reset();
        for (int i = 0; i < 4; i++) add_txn(1'b1, 1'b0, 1'b1, rbit(), 0, 0);
        add_txn(1'b0, 1'b1, 1'b1, rbit(), 0, 0);
        add_txn(1'b1, 1'b1, 1'b1, rbit(), 0, 0);
        apply_queue();
        foreach (q[i]) begin
            n_cmp++;
            if (obs[i] !== q[i].exp) begin
                n_bad++;
                $display("FAIL read_hit[%0d]: got %b want %b", i, obs[i], q[i].exp);
            end
        end
    endtask

    task automatic test_clean_miss();
        int n_rd;
        int resp_at;
        do_reset();
        add_txn(1'b1, 1'b0, 1'b0, 1'b0, 0, 3);
        apply_queue();
        n_rd = 0;
        resp_at = -1;
        foreach (q[i]) begin
            n_cmp++;
            if (obs[i] !== q[i].exp) begin
                n_bad++;
                $display("FAIL clean_miss[%0d]: got %b want %b", i, obs[i], q[i].exp);
            end
            if (obs[i][1]) n_rd++;
            if (obs[i][2] && resp_at < 0) resp_at = i;
        end
        n_cmp++;
        if (n_rd !== 3) begin
            n_bad++;
            $display("FAIL clean_miss_read_cycles: got %0d want 3", n_rd);
        end
        n_cmp++;
        if (resp_at !== 5) begin
            n_bad++;
            $display("FAIL clean_miss_latency: got %0d want 5", resp_at);
        end
    endtask

    task automatic test_dirty_write_miss();
        do_reset();
        add_txn(1'b0, 1'b1, 1'b0, 1'b1, 2, 2);
        add_txn(1'b1, 1'b1, 1'b0, 1'b1, 1, 1);
        apply_queue();
        foreach (q[i]) begin
            n_cmp++;
            if (obs[i] !== q[i].exp) begin
                n_bad++;
                $display("FAIL dirty_write_miss[%0d]: got %b want %b", i, obs[i], q[i].exp);
            end
        end
    endtask

    task automatic test_stray_resp();
        do_reset();
        for (int i = 0; i < 4; i++) add_idle(1'b1);
        add_txn(1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
        apply_queue();
        foreach (q[i]) begin
            n_cmp++;
            if (obs[i] !== q[i].exp) begin
                n_bad++;
                $display("FAIL stray_resp[%0d]: got %b want %b", i, obs[i], q[i].exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        int overlap;
        bit rd, wr;
        do_reset();
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(3, 0) == 0) add_idle(1'b0);
            rd = rbit();
            wr = rd ? rbit() : 1'b1;
            add_txn(rd, wr, rbit(), rbit(), int'($urandom_range(4, 1)), int'($urandom_range(4, 1)));
        end
        apply_queue();
        overlap = 0;
        foreach (q[i]) begin
            n_cmp++;
            if (obs[i] !== q[i].exp) begin
                n_bad++;
                $display("FAIL back_to_back[%0d]: got %b want %b", i, obs[i], q[i].exp);
            end
            if (obs[i][1] && obs[i][0]) overlap++;
        end
        n_cmp++;
        if (overlap !== 0) begin
            n_bad++;
            $display("FAIL pmem_rw_exclusive: got %0d overlapping cycles want 0", overlap);
        end
`ifdef CACHE_PERF_EN
        n_cmp++;
        if (hit_count !== CNT_W'(m_hits) || miss_count !== CNT_W'(m_miss) || wb_count !== CNT_W'(m_wb)) begin
            n_bad++;
            $display("FAIL b2b_counters: got %0d/%0d/%0d want %0d/%0d/%0d",
                     hit_count, miss_count, wb_count, m_hits, m_miss, m_wb);
        end
`endif
    endtask

    task automatic test_reset_mid_wb();
        do_reset();
        write_i = 1; cache_hit = 0; dirty = 1; pmem_resp = 0;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++;
        if (outs !== ov(0, 0, 1, 0, 1, 0, 0, 1)) begin
            n_bad++;
            $display("FAIL mid_wb_active: got %b want %b", outs, ov(0, 0, 1, 0, 1, 0, 0, 1));
        end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (outs !== 8'h00) begin
            n_bad++;
            $display("FAIL mid_wb_reset_drop: got %b want %b", outs, 8'h00);
        end
        @(posedge clk);
        #1;
        write_i = 0; read_i = 1; cache_hit = 1; dirty = 0;
        #1;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (outs !== ov(0, 1, 0, 0, 0, 1, 0, 0)) begin
            n_bad++;
            $display("FAIL mid_wb_after_release: got %b want %b", outs, ov(0, 1, 0, 0, 0, 1, 0, 0));
        end
        @(posedge clk);
        #1;
        read_i = 0; cache_hit = 0;
    endtask

`ifdef CACHE_PERF_EN
    task automatic test_perf();
        do_reset();
        for (int i = 0; i < 3; i++) add_txn(1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
        add_txn(1'b1, 1'b0, 1'b0, 1'b0, 0, 2);
        add_txn(1'b0, 1'b1, 1'b0, 1'b1, 1, 1);
        apply_queue();
        foreach (q[i]) begin
            n_cmp++;
            if (obs2[i] !== q[i].exp) begin
                n_bad++;
                $display("FAIL perf_trace_w2[%0d]: got %b want %b", i, obs2[i], q[i].exp);
            end
        end
        n_cmp++;
        if (hit_count !== CNT_W'(m_hits) || miss_count !== CNT_W'(m_miss) || wb_count !== CNT_W'(m_wb)) begin
            n_bad++;
            $display("FAIL perf_counters: got %0d/%0d/%0d want %0d/%0d/%0d",
                     hit_count, miss_count, wb_count, m_hits, m_miss, m_wb);
        end
        q.delete();
        for (int i = 0; i < 2; i++) add_txn(1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
        apply_queue();
        n_cmp++;
        if (hit_count !== CNT_W'(m_hits)) begin
            n_bad++;
            $display("FAIL perf_hits_wide: got %0d want %0d", hit_count, m_hits);
        end
        n_cmp++;
        if (s_hit_count !== 2'(sat(m_hits, 3)) || s_miss_count !== 2'(sat(m_miss, 3)) ||
            s_wb_count !== 2'(sat(m_wb, 3))) begin
            n_bad++;
            $display("FAIL perf_saturate_w2: got %0d/%0d/%0d want %0d/%0d/%0d", s_hit_count, s_miss_count,
                     s_wb_count, sat(m_hits, 3), sat(m_miss, 3), sat(m_wb, 3));
        end
    endtask
`endif

    initial begin
        test_reset();
        test_read_hit();
        test_clean_miss();
        test_dirty_write_miss();
        test_stray_resp();
        test_back_to_back();
        test_reset_mid_wb();
`ifdef CACHE_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
